// File: rtl/mem_rd_arbiter_if.sv
// Bundle of the two burst-request channels, the shared memory read port and the
// tagged response stream of mem_rd_arbiter.
interface mem_rd_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [ADDR_W-1:0] req0_len;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [ADDR_W-1:0] req1_len;
    logic              req1_ready;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_last;
    logic              busy;

    modport slave (
        input  req0_valid, req0_addr, req0_len,
        output req0_ready,
        input  req1_valid, req1_addr, req1_len,
        output req1_ready,
        output mem_en, mem_addr,
        input  mem_rdata,
        output rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );

    modport master (
        output req0_valid, req0_addr, req0_len,
        input  req0_ready,
        output req1_valid, req1_addr, req1_len,
        input  req1_ready,
        input  mem_en, mem_addr,
        output mem_rdata,
        input  rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-requester round-robin burst read arbiter over one synchronous-read memory;
// walks a wrapping address counter and returns beats tagged with owner and last flag.
module mem_rd_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    mem_rd_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] remaining_r;
    logic              owner_r;
    logic              last_grant_r;
    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic              rsp_last_r;
    logic              sel_valid_s;
    logic              sel_id_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [ADDR_W-1:0] sel_len_s;
    logic              accept_s;
    logic              last_beat_s;
    logic [DATA_W-1:0] rsp_data_s;

    // Requester selection: a tie goes to whoever was not granted last.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_id_s    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = ~last_grant_r;
        end else if (bus.req0_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = 1'b0;
        end else if (bus.req1_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = 1'b1;
        end else begin
            sel_valid_s = 1'b0;
            sel_id_s    = 1'b0;
        end
        if (sel_id_s) begin
            sel_addr_s = bus.req1_addr;
            sel_len_s  = bus.req1_len;
        end else begin
            sel_addr_s = bus.req0_addr;
            sel_len_s  = bus.req0_len;
        end
    end

    assign accept_s    = (state_r == ST_IDLE) && sel_valid_s;
    assign last_beat_s = (state_r == ST_BURST) && (remaining_r == ADDR_ZERO);

    // Next-state logic: a burst never yields until its final read is issued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Burst bookkeeping; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur_addr_r   <= ADDR_ZERO;
            remaining_r  <= ADDR_ZERO;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            cur_addr_r   <= sel_addr_s;
            remaining_r  <= sel_len_s;
            owner_r      <= sel_id_s;
            last_grant_r <= sel_id_s;
        end else if (state_r == ST_BURST) begin
            cur_addr_r   <= cur_addr_r + ADDR_ONE;
            remaining_r  <= remaining_r - ADDR_ONE;
            owner_r      <= owner_r;
            last_grant_r <= last_grant_r;
        end else begin
            cur_addr_r   <= cur_addr_r;
            remaining_r  <= remaining_r;
            owner_r      <= owner_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Response tags trail the read issue by one cycle to line up with mem_rdata.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_last_r  <= 1'b0;
        end else begin
            rsp_valid_r <= (state_r == ST_BURST);
            rsp_id_r    <= owner_r;
            rsp_last_r  <= last_beat_s;
        end
    end

    assign rsp_data_s     = bus.mem_rdata;
    assign bus.req0_ready = accept_s && !sel_id_s;
    assign bus.req1_ready = accept_s && sel_id_s;
    assign bus.mem_en     = (state_r == ST_BURST);
    assign bus.mem_addr   = cur_addr_r;
    assign bus.busy       = (state_r == ST_BURST);
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_s;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_last   = rsp_last_r;
endmodule
